fetch_unit: RTL

Instruction fetch stage for the 8-bit processor. Reads two consecutive bytes from the single-port synchronous program/data RAM: opcode at PC, operand at PC+1. Presents each assembled instruction to the decoder through a valid/ready handshake. Sits directly upstream of the decoder and drives the RAM's read address. Accepts PC redirects from the execute stage for jumps and branches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        OP_REQ,
        OP_CAP,
        ARG_CAP,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam int         FETCH_INSTR_BYTES = 2;
    localparam logic [7:0] HALT_OP_DEFAULT   = 8'hFF;

endpackage

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch (opcode at pc, operand at pc+1) with valid/ready issue and PC redirect.
// Optional halt-opcode support is built when FETCH_HALT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_HALT_EN
    ,
    parameter logic [DATA_W-1:0] HALT_OP  = DATA_W'(HALT_OP_DEFAULT)
`endif
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FETCH_INSTR_BYTES);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              instr_valid_q, instr_valid_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            OP_REQ: state_d = OP_CAP;
            OP_CAP: begin
                opcode_d   = ram_q;
                instr_pc_d = pc_q;
                state_d    = ARG_CAP;
            end
            ARG_CAP: begin
                operand_d     = ram_q;
                instr_valid_d = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (instr_valid_q && instr_ready) begin
                    pc_d          = pc_q + PC_STEP;
                    instr_valid_d = 1'b0;
                    state_d       = OP_REQ;
`ifdef FETCH_HALT_EN
                    if (opcode_q == HALT_OP) state_d = HALTED;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALTED: state_d = HALTED;
`endif
            default: state_d = OP_REQ;
        endcase

        // A redirect overrides the sequencer; a handshake in the same cycle still completes.
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            state_d       = OP_REQ;
            instr_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= OP_REQ;
            pc_q          <= RESET_PC;
            instr_pc_q    <= '0;
            opcode_q      <= '0;
            operand_q     <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Operand byte is addressed while the opcode is being captured.
    assign ram_address = (state_q == OP_CAP || state_q == ARG_CAP) ? pc_q + ADDR_W'(1) : pc_q;
    assign ram_wren    = 1'b0;
    assign instr_valid = instr_valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_pc    = instr_pc_q;

endmodule
